conf_loader: RTL

//   Parametrised CGRA configuration loader. Fetches one initial-configuration line, then NUM configuration words

---
 rtl/conf_loader_pkg.sv | 26 ++
 rtl/conf_loader_if.sv | 34 +++
 rtl/conf_line_unpacker.sv | 41 ++++
 rtl/conf_loader.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/conf_loader_pkg.sv
// Shared definitions for the CGRA configuration loader.
//   state_t    : loader FSM states (the checksum states are only reachable
//                when CONF_LOADER_CHECKSUM_EN is defined)
//   STATE_W    : encoded state width
//   idx_width(): width of the per-line word index, able to hold 0..CONF_PER_LINE
package conf_loader_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 4'd0,
        REQ_INIT = 4'd1,
        CAP_INIT = 4'd2,
        REQ_LINE = 4'd3,
        CAP_LINE = 4'd4,
        EMIT     = 4'd5,
        REQ_CHK  = 4'd6,
        CAP_CHK  = 4'd7,
        DONE     = 4'd8
    } state_t;

    function automatic int idx_width(input int per_line);
        return $clog2(per_line + 1);
    endfunction

endpackage

// File: rtl/conf_loader_if.sv
// Host read stream plus configuration-memory write port of the loader.
//   rd_avail      : host has a line available
//   rd_data       : line data
//   rd_req        : one-cycle line request
//   wr_conf       : configuration write strobe
//   conf_out      : configuration word
//   conf_addr_out : configuration write address
// Handshake: rd_req is raised for exactly one cycle and only while rd_avail
// is 1 (rd_avail acts as ready, rd_req as the accepted request); the host
// must present the requested line on rd_data throughout the following cycle.
// The write port has no back-pressure: every cycle with wr_conf=1 is a write.
// Modports: master = loader side, slave = host/RAM side.
interface conf_loader_if #(
    parameter int DATA_W = 512,
    parameter int CONF_W = 352,
    parameter int ADDR_W = 10
);
    logic              rd_avail;
    logic [DATA_W-1:0] rd_data;
    logic              rd_req;
    logic              wr_conf;
    logic [CONF_W-1:0] conf_out;
    logic [ADDR_W-1:0] conf_addr_out;

    modport master (
        input  rd_avail, rd_data,
        output rd_req, wr_conf, conf_out, conf_addr_out
    );

    modport slave (
        output rd_avail, rd_data,
        input  rd_req, wr_conf, conf_out, conf_addr_out
    );
endinterface

// File: rtl/conf_line_unpacker.sv
// Holds one host line and presents configuration word idx of it.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture line_in
//   line_in  : packed words, word k at line_in[k*CONF_W +: CONF_W]
//   idx      : word index within the held line
//   word     : selected word (0 if idx is out of range)
//   last     : idx addresses the final word of the line
module conf_line_unpacker #(
    parameter int CONF_W        = 352,
    parameter int CONF_PER_LINE = 1,
    parameter int IDX_W         = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [CONF_PER_LINE*CONF_W-1:0] line_in,
    input  logic [IDX_W-1:0]                idx,
    output logic [CONF_W-1:0]               word,
    output logic                            last
);
    logic [CONF_PER_LINE*CONF_W-1:0] line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= line_in;
        end
    end

    always_comb begin
        word = '0;
        for (int k = 0; k < CONF_PER_LINE; k++) begin
            if (idx == IDX_W'(k)) begin
                word = line_q[k*CONF_W +: CONF_W];
            end
        end
    end

    assign last = (idx == IDX_W'(CONF_PER_LINE - 1));
endmodule

// File: rtl/conf_loader.sv
// CGRA configuration loader. Fetches one initial-configuration line, then
// num_conf configuration words from the host read stream, unpacking
// CONF_PER_LINE words per line onto the configuration-memory write port.
// Optional feature macro: CONF_LOADER_CHECKSUM_EN -- fetch one trailer line
// after the last word and flag error when its low CONF_W bits differ from the
// XOR of all words written in this load.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : launch pulse, ignored while busy
//   num_conf      : words to load (sampled on accepted start)
//   base_addr     : first write address (sampled on accepted start)
//   bus           : host read stream + config write port (master side)
//   initial_conf  : captured initial-configuration line
//   busy, done    : load in progress / load complete (held until next start)
//   error         : checksum mismatch, valid with done
//   dbg_state     : current FSM state
module conf_loader
    import conf_loader_pkg::*;
#(
    parameter int DATA_W        = 512,
    parameter int CONF_W        = 352,
    parameter int ADDR_W        = 10,
    parameter int CNT_W         = 32,
    parameter int CONF_PER_LINE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_conf,
    input  logic [ADDR_W-1:0] base_addr,
    conf_loader_if.master     bus,
    output logic [DATA_W-1:0] initial_conf,
    output logic              busy,
    output logic              done,
    output logic              error,
    output state_t            dbg_state
);
    localparam int IDX_W  = idx_width(CONF_PER_LINE);
    localparam int LINE_W = CONF_PER_LINE * CONF_W;

`ifdef CONF_LOADER_CHECKSUM_EN
    localparam state_t FIN_STATE = REQ_CHK;
`else
    localparam state_t FIN_STATE = DONE;
`endif

    state_t            state, state_next;
    logic [CNT_W-1:0]  num_q, cnt, cnt_inc;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic [CONF_W-1:0] word;
    logic              last_in_line, start_ok, rd_req_c, wr_conf_c;

    assign cnt_inc  = cnt + CNT_W'(1);
    assign start_ok = start && (state == IDLE || state == DONE);

    conf_line_unpacker #(
        .CONF_W        (CONF_W),
        .CONF_PER_LINE (CONF_PER_LINE),
        .IDX_W         (IDX_W)
    ) u_unpacker (
        .clk     (clk),
        .rst     (rst),
        .load    (state == CAP_LINE),
        .line_in (bus.rd_data[LINE_W-1:0]),
        .idx     (idx),
        .word    (word),
        .last    (last_in_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_req_c   = 1'b0;
        wr_conf_c  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = REQ_INIT;
            end
            REQ_INIT: begin
                if (bus.rd_avail) begin
                    rd_req_c   = 1'b1;
                    state_next = CAP_INIT;
                end
            end
            CAP_INIT: state_next = (num_q != '0) ? REQ_LINE : FIN_STATE;
            REQ_LINE: begin
                if (bus.rd_avail) begin
                    rd_req_c   = 1'b1;
                    state_next = CAP_LINE;
                end
            end
            CAP_LINE: state_next = EMIT;
            EMIT: begin
                wr_conf_c = 1'b1;
                // Leave on the final word of the line or the final word of
                // the load, whichever comes first; tail words are dropped.
                if (last_in_line || cnt_inc == num_q) begin
                    state_next = (cnt_inc < num_q) ? REQ_LINE : FIN_STATE;
                end
            end
`ifdef CONF_LOADER_CHECKSUM_EN
            REQ_CHK: begin
                if (bus.rd_avail) begin
                    rd_req_c   = 1'b1;
                    state_next = CAP_CHK;
                end
            end
            CAP_CHK: state_next = DONE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q        <= '0;
            cnt          <= '0;
            addr         <= '0;
            idx          <= '0;
            initial_conf <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_q <= num_conf;
                        addr  <= base_addr;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                CAP_INIT: initial_conf <= bus.rd_data;
                CAP_LINE: idx <= '0;
                EMIT: begin
                    addr <= addr + ADDR_W'(1);  // wraps modulo 2^ADDR_W
                    cnt  <= cnt_inc;
                    idx  <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef CONF_LOADER_CHECKSUM_EN
    logic [CONF_W-1:0] csum;
    logic              error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum    <= '0;
            error_q <= 1'b0;
        end else if (start_ok) begin
            csum    <= '0;
            error_q <= 1'b0;
        end else if (state == EMIT) begin
            csum <= csum ^ word;
        end else if (state == CAP_CHK) begin
            error_q <= (bus.rd_data[CONF_W-1:0] != csum);
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign bus.rd_req        = rd_req_c;
    assign bus.wr_conf       = wr_conf_c;
    assign bus.conf_out      = word;
    assign bus.conf_addr_out = addr;
    assign busy              = (state != IDLE) && (state != DONE);
    assign done              = (state == DONE);
    assign dbg_state         = state;
endmodule
